// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache refill controller.
// Holds the controller state encoding and the default geometry constants.
package icache_pkg;

  localparam int IC_WORD_SIZE     = 64;
  localparam int IC_LINE_WORDS    = 8;
  localparam int IC_SIZE_IN_WORDS = 1024;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FILL,
    DONE,
    FLUSH
  } icfill_state_t;

endpackage

// File: rtl/icache_port0_arb.sv
// Port-0 arbiter for the icache data SRAM: a refill/flush write always beats a
// debug read in the same cycle. Also tracks outstanding debug reads through the
// two-cycle SRAM read path (macro cycle plus wrapper output register).
module icache_port0_arb
  import icache_pkg::*;
#(
  parameter int ADDR_LEN  = $clog2(IC_SIZE_IN_WORDS),
  parameter int WORD_SIZE = IC_WORD_SIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [ADDR_LEN-1:0]    wr_addr,
  input  logic [WORD_SIZE-1:0]   wr_data,
  input  logic                   dbg_valid,
  input  logic [ADDR_LEN-1:0]    dbg_addr,
  output logic                   dbg_ready,
  output logic                   dbg_rvalid,
  output logic [WORD_SIZE-1:0]   dbg_rdata,
  output logic                   sram_nce0,
  output logic                   sram_nwe0,
  output logic [ADDR_LEN-1:0]    sram_addr0,
  output logic [WORD_SIZE-1:0]   sram_wdata0,
  output logic [WORD_SIZE/8-1:0] sram_wmask0,
  input  logic [WORD_SIZE-1:0]   sram_rdata0
);

  logic [ADDR_LEN-1:0]  hold_addr_q;
  logic [WORD_SIZE-1:0] hold_wdata_q;
  logic [1:0]           rd_pipe_q;

  assign dbg_ready   = dbg_valid & ~wr_en;
  assign sram_wmask0 = '1;

  // Port-0 mux: write first, then debug read; an idle port keeps its last address/data
  always_comb begin
    sram_nce0   = 1'b1;
    sram_nwe0   = 1'b1;
    sram_addr0  = hold_addr_q;
    sram_wdata0 = hold_wdata_q;
    if (wr_en) begin
      sram_nce0   = 1'b0;
      sram_nwe0   = 1'b0;
      sram_addr0  = wr_addr;
      sram_wdata0 = wr_data;
    end else if (dbg_ready) begin
      sram_nce0  = 1'b0;
      sram_addr0 = dbg_addr;
    end
  end

  // Remember the last driven address/data and shift debug grants toward dbg_rvalid
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      rd_pipe_q    <= '0;
    end else begin
      if (!sram_nce0) begin
        hold_addr_q  <= sram_addr0;
        hold_wdata_q <= sram_wdata0;
      end
      rd_pipe_q <= {rd_pipe_q[0], dbg_ready};
    end
  end

  assign dbg_rvalid = rd_pipe_q[1];
  assign dbg_rdata  = rd_pipe_q[1] ? sram_rdata0 : '0;

endmodule

// File: rtl/icache_fill_ctrl.sv
// Instruction-cache refill controller owning SRAM port 0.
// Requests a missing line from memory, writes the returned beats into the data
// SRAM and shares the port with debug reads (writes take priority).
// Define ICFILL_FLUSH_EN to add the flush_req/flush_busy ports and the
// full-array zeroing walk; without it the controller only refills.
module icache_fill_ctrl
  import icache_pkg::*;
#(
  parameter int SIZE_IN_WORDS = IC_SIZE_IN_WORDS,
  parameter int WORD_SIZE     = IC_WORD_SIZE,
  parameter int LINE_WORDS    = IC_LINE_WORDS,
  parameter int ADDR_LEN      = $clog2(SIZE_IN_WORDS),
  parameter int LINE_IDX_LEN  = ADDR_LEN - $clog2(LINE_WORDS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss_valid,
  output logic                    miss_ready,
  input  logic [LINE_IDX_LEN-1:0] miss_line,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [LINE_IDX_LEN-1:0] mem_req_line,
  input  logic                    mem_rvalid,
  input  logic [WORD_SIZE-1:0]    mem_rdata,
  output logic                    fill_done,
  output logic [LINE_IDX_LEN-1:0] fill_line,
  input  logic                    dbg_valid,
  output logic                    dbg_ready,
  input  logic [ADDR_LEN-1:0]     dbg_addr,
  output logic                    dbg_rvalid,
  output logic [WORD_SIZE-1:0]    dbg_rdata,
`ifdef ICFILL_FLUSH_EN
  input  logic                    flush_req,
  output logic                    flush_busy,
`endif
  output logic                    sram_nce0,
  output logic                    sram_nwe0,
  output logic [ADDR_LEN-1:0]     sram_addr0,
  output logic [WORD_SIZE-1:0]    sram_wdata0,
  output logic [WORD_SIZE/8-1:0]  sram_wmask0,
  input  logic [WORD_SIZE-1:0]    sram_rdata0
);

  localparam int BEAT_LEN = $clog2(LINE_WORDS);
  localparam logic [BEAT_LEN-1:0] LAST_BEAT = BEAT_LEN'(LINE_WORDS - 1);

  icfill_state_t state_q, state_d;
  logic [LINE_IDX_LEN-1:0] line_q;
  logic [BEAT_LEN-1:0]     beat_cnt_q;
  logic                    miss_accept;
  logic                    fill_beat;
  logic                    wr_en;
  logic [ADDR_LEN-1:0]     wr_addr;
  logic [WORD_SIZE-1:0]    wr_data;

`ifdef ICFILL_FLUSH_EN
  localparam logic [ADDR_LEN-1:0] LAST_WORD = ADDR_LEN'(SIZE_IN_WORDS - 1);
  logic                flush_pend_q;
  logic [ADDR_LEN-1:0] flush_addr_q;

  assign flush_busy = flush_pend_q;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and the write request handed to the port-0 arbiter
  always_comb begin
    state_d       = state_q;
    miss_ready    = 1'b0;
    mem_req_valid = 1'b0;
    fill_done     = 1'b0;
    miss_accept   = 1'b0;
    fill_beat     = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = {line_q, beat_cnt_q};
    wr_data       = mem_rdata;
    case (state_q)
`ifdef ICFILL_FLUSH_EN
      IDLE: begin
        if (flush_pend_q) begin
          state_d = FLUSH;
        end else begin
          miss_ready = 1'b1;
          if (miss_valid) begin
            miss_accept = 1'b1;
            state_d     = REQ;
          end
        end
      end
`else
      IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) begin
          miss_accept = 1'b1;
          state_d     = REQ;
        end
      end
`endif
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (mem_rvalid) begin
          fill_beat = 1'b1;
          wr_en     = 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        fill_done = 1'b1;
`ifdef ICFILL_FLUSH_EN
        state_d = flush_pend_q ? FLUSH : IDLE;
`else
        state_d = IDLE;
`endif
      end
`ifdef ICFILL_FLUSH_EN
      FLUSH: begin
        wr_en   = 1'b1;
        wr_addr = flush_addr_q;
        wr_data = '0;
        if (flush_addr_q == LAST_WORD) begin
          state_d = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Latch the missing line and step the beat counter as beats are written
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q     <= '0;
      beat_cnt_q <= '0;
    end else if (miss_accept) begin
      line_q     <= miss_line;
      beat_cnt_q <= '0;
    end else if (fill_beat) begin
      beat_cnt_q <= (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + BEAT_LEN'(1);
    end
  end

`ifdef ICFILL_FLUSH_EN
  // Hold a flush request until the walk over every word has finished
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_pend_q <= 1'b0;
      flush_addr_q <= '0;
    end else begin
      if (flush_req && !flush_pend_q) begin
        flush_pend_q <= 1'b1;
      end
      if (state_q == FLUSH) begin
        if (flush_addr_q == LAST_WORD) begin
          flush_addr_q <= '0;
          flush_pend_q <= 1'b0;
        end else begin
          flush_addr_q <= flush_addr_q + ADDR_LEN'(1);
        end
      end
    end
  end
`endif

  assign mem_req_line = line_q;
  assign fill_line    = fill_done ? line_q : '0;

  icache_port0_arb #(
    .ADDR_LEN  (ADDR_LEN),
    .WORD_SIZE (WORD_SIZE)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .dbg_valid   (dbg_valid),
    .dbg_addr    (dbg_addr),
    .dbg_ready   (dbg_ready),
    .dbg_rvalid  (dbg_rvalid),
    .dbg_rdata   (dbg_rdata),
    .sram_nce0   (sram_nce0),
    .sram_nwe0   (sram_nwe0),
    .sram_addr0  (sram_addr0),
    .sram_wdata0 (sram_wdata0),
    .sram_wmask0 (sram_wmask0),
    .sram_rdata0 (sram_rdata0)
  );

endmodule
